weight_loader: RTL and testbench

//  Streaming writer that fills the network's weight/bias BRAMs (W1, B1, W2, B2) from a byte stream
//  (host link / UART receiver). It is the write-side counterpart of the read-only weight memory feeding the MAC arrays.
//  One load sequence per start pulse, in fixed section order W1 -> B1 -> W2 -> B2.

---
 rtl/weight_loader_if.sv | 38 +++
 rtl/weight_loader.sv | 189 ++++++++++++++++++
 tb/tb_weight_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : weight_loader_if
//  Brief    : Byte-stream input and registered BRAM write port of weight_loader
//  Revision : 1.0  initial release
// ============================================================================
interface weight_loader_if #(
    parameter int AW = 15
);
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_sel,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_sel,
        output wr_addr,
        output wr_data
    );
endinterface
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : weight_loader
//  Brief    : Streams bytes into W1/B1/W2/B2 weight BRAMs, one write per byte.
//             Optional trailing checksum byte enabled by WL_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module weight_loader #(
    parameter int N_IN  = 784,
    parameter int N_HID = 32,
    parameter int N_OUT = 10,
    parameter int AW    = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    weight_loader_if.slave bus,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);
    localparam int c_w1_last = N_IN * N_HID - 1;
    localparam int c_b1_last = N_HID - 1;
    localparam int c_w2_last = N_HID * N_OUT - 1;
    localparam int c_b2_last = N_OUT - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_W1   = 3'd1,
        S_LD_B1   = 3'd2,
        S_LD_W2   = 3'd3,
        S_LD_B2   = 3'd4,
`ifdef WL_CHECKSUM_EN
        S_LD_CSUM = 3'd5,
`endif
        S_FINISH  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [1:0]    wr_sel_q, wr_sel_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef WL_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
    logic          err_q, err_d;
`endif

    logic          w_load;
    logic          w_xfer;
    logic [1:0]    w_sec;
    logic [AW-1:0] w_last;
    state_t        w_next;

    // Per-state section decode: target memory, last address, successor state
    always_comb begin
        w_load = 1'b1;
        w_sec  = 2'd0;
        w_last = '0;
        w_next = S_IDLE;
        case (state_q)
            S_LD_W1: begin w_sec = 2'd0; w_last = AW'(c_w1_last); w_next = S_LD_B1; end
            S_LD_B1: begin w_sec = 2'd1; w_last = AW'(c_b1_last); w_next = S_LD_W2; end
            S_LD_W2: begin w_sec = 2'd2; w_last = AW'(c_w2_last); w_next = S_LD_B2; end
            S_LD_B2: begin
                w_sec  = 2'd3;
                w_last = AW'(c_b2_last);
`ifdef WL_CHECKSUM_EN
                w_next = S_LD_CSUM;
`else
                w_next = S_FINISH;
`endif
            end
`ifdef WL_CHECKSUM_EN
            S_LD_CSUM: w_load = 1'b1;
`endif
            default: w_load = 1'b0;
        endcase
    end

    assign w_xfer = w_load & bus.in_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef WL_CHECKSUM_EN
        csum_d    = csum_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LD_W1;
                    cnt_d   = '0;
`ifdef WL_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_LD_W1, S_LD_B1, S_LD_W2, S_LD_B2: begin
                if (w_xfer) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = w_sec;
                    wr_addr_d = cnt_q;
                    wr_data_d = bus.in_data;
`ifdef WL_CHECKSUM_EN
                    csum_d    = csum_q + bus.in_data;
`endif
                    // Section change happens on the same edge as the last byte
                    if (cnt_q == w_last) begin
                        cnt_d   = '0;
                        state_d = w_next;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
`ifdef WL_CHECKSUM_EN
            S_LD_CSUM: begin
                if (w_xfer) begin
                    if (bus.in_data == csum_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 2'd0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef WL_CHECKSUM_EN
            csum_q    <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef WL_CHECKSUM_EN
            csum_q    <= csum_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.in_ready = w_load;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_sel   = wr_sel_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
`ifdef WL_CHECKSUM_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_loader
//  Brief    : Self-checking bench for weight_loader against a byte-index model
//  Revision : 1.0  initial release
// ============================================================================
module tb_weight_loader;
    localparam int AW    = 15;
    localparam int W1_N  = 784 * 32;
    localparam int B1_N  = 32;
    localparam int W2_N  = 32 * 10;
    localparam int B2_N  = 10;
    localparam int TOTAL = W1_N + B1_N + W2_N + B2_N;
`ifdef WL_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err;

    weight_loader_if #(.AW(AW)) bus ();

    weight_loader #(.N_IN(784), .N_HID(32), .N_OUT(10), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .bus     (bus),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    int n_done = 0;

    // Reference model: position in the flat byte stream plus load/finish flags
    bit            m_loading = 1'b0;
    bit            m_fin     = 1'b0;
    bit            m_err     = 1'b0;
    int            m_k       = 0;
    logic [7:0]    m_sum     = 8'd0;
    bit            e_wr, e_busy, e_done;
    logic [1:0]    e_sel;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void addr_of(input int k, output logic [1:0] sel, output logic [AW-1:0] addr);
        if (k < W1_N) begin
            sel = 2'd0; addr = AW'(k);
        end else if (k < W1_N + B1_N) begin
            sel = 2'd1; addr = AW'(k - W1_N);
        end else if (k < W1_N + B1_N + W2_N) begin
            sel = 2'd2; addr = AW'(k - W1_N - B1_N);
        end else begin
            sel = 2'd3; addr = AW'(k - W1_N - B1_N - W2_N);
        end
    endfunction

    // One clock cycle: drive after negedge, predict, check 1 time unit after posedge
    task automatic step(input bit v, input logic [7:0] d, input bit st);
        bit xfer, idle, nfin;
        start        = st;
        bus.in_valid = v;
        bus.in_data  = d;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(m_loading));
        xfer   = v && m_loading;
        idle   = !m_loading && !m_fin;
        e_done = m_fin;
        e_wr   = 1'b0;
        nfin   = 1'b0;
        if (idle && st) begin
            m_loading = 1'b1;
            m_k       = 0;
            m_err     = 1'b0;
            m_sum     = 8'd0;
        end else if (xfer) begin
            if (m_k < TOTAL) begin
                e_wr = 1'b1;
                addr_of(m_k, e_sel, e_addr);
                e_data = d;
                m_sum  = m_sum + d;
                m_k++;
                if (m_k == TOTAL && !CSUM) begin
                    m_loading = 1'b0;
                    nfin      = 1'b1;
                end
            end else begin
                m_loading = 1'b0;
                if (d == m_sum) nfin = 1'b1;
                else            m_err = 1'b1;
            end
        end
        m_fin  = nfin;
        e_busy = m_loading || m_fin;
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) n_wr++;
        if (done === 1'b1) n_done++;
        chk("wr_en", 32'(bus.wr_en), 32'(e_wr));
        if (e_wr) begin
            chk("wr_sel", 32'(bus.wr_sel), 32'(e_sel));
            chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
            chk("wr_data", 32'(bus.wr_data), 32'(e_data));
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(m_err));
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        int guard;

        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
        chk("rst_wr_sel",   32'(bus.wr_sel),   32'd0);
        chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_done",     32'(done),         32'd0);
        chk("rst_err",      32'(err),          32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h55, 1'b0);   // valid while idle must not be taken

        // Load A: in_valid held high, byte = index mod 256, stray start at byte 100
        n_wr = 0; n_done = 0; guard = 0;
        step(1'b0, 8'd0, 1'b1);
        while ((m_loading || m_fin) && guard < 30000) begin
            d = (m_k < TOTAL) ? m_k[7:0] : m_sum;
            step(1'b1, d, m_k == 100);
            guard++;
        end
        chk("loadA_finished", 32'(m_loading || m_fin), 32'd0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("loadA_wr_count", 32'(n_wr), 32'(TOTAL));
        chk("loadA_done_count", 32'(n_done), 32'd1);

        // Load B: random gaps and data, rst just as W2 address 50 is offered
        guard = 0;
        step(1'b0, 8'd0, 1'b1);
        while (m_k < W1_N + B1_N + 50 && guard < 80000) begin
            step(($urandom_range(0, 2) != 0), 8'($urandom), 1'b0);
            guard++;
        end
        chk("loadB_reached_w2", 32'(m_k), 32'(W1_N + B1_N + 50));
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'($urandom); start = 1'b0;
        @(posedge clk); #1;
        chk("abort_wr_en",    32'(bus.wr_en),    32'd0);
        chk("abort_busy",     32'(busy),         32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_done",     32'(done),         32'd0);
        m_loading = 1'b0; m_fin = 1'b0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Restart after abort must begin again at W1 address 0
        step(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 1) != 0), 8'($urandom), 1'b0);
        end

`ifdef WL_CHECKSUM_EN
        // Wrong checksum byte: err set, no done, next start clears err
        rst = 1'b1;
        @(posedge clk); #1;
        m_loading = 1'b0; m_fin = 1'b0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_done = 0; guard = 0;
        step(1'b0, 8'd0, 1'b1);
        while ((m_loading || m_fin) && guard < 30000) begin
            d = (m_k < TOTAL) ? 8'($urandom) : (m_sum + 8'd1);
            step(1'b1, d, 1'b0);
            guard++;
        end
        step(1'b0, 8'd0, 1'b0);
        chk("csum_bad_done_count", 32'(n_done), 32'd0);
        chk("csum_bad_err", 32'(err), 32'd1);
        step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd7, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
